// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive controller and its baud counter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

  localparam int CLKS_PER_BIT_DEFAULT = 434;
  localparam int PARITY_EVEN          = 0;
  localparam int PARITY_ODD           = 1;
  localparam int DATA_BITS            = 8;
endpackage

// File: rtl/uart_baud_tick.sv
// Loadable down-counter; tick is high while the count sits at zero.
module uart_baud_tick #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = load_val;
    else if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);
endmodule

// File: rtl/uart_rx_controller.sv
// UART receive controller: 2-FF sync, start/data/parity/stop sequencing, held byte + flags.
// Define UART_RX_PARITY_EN for an 11-bit frame with a parity bit; default build is 8N1.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int PARITY_ODD   = PARITY_EVEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  input  logic       rx_clr,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int               CNT_W       = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD   = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             PAR_ODD_BIT = (PARITY_ODD != PARITY_EVEN);

  uart_state_e          state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_s, tick, cnt_load;
  logic [CNT_W-1:0]     cnt_val;

  assign rx_s = sync_q[1];

  uart_baud_tick #(.CNT_W(CNT_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (tick)
  );

  always_comb begin
    sync_d       = {sync_q[0], uart_rx};
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_ready_d   = rx_ready_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    cnt_load     = 1'b0;
    cnt_val      = BIT_LOAD;

    // A commit in STOP below overrides this clear in the same cycle.
    if (rx_clr) begin
      rx_ready_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      IDLE: if (!rx_s) begin
        state_d  = START;
        cnt_load = 1'b1;
        cnt_val  = HALF_LOAD;
      end
      START: if (tick) begin
        if (rx_s) state_d = IDLE;
        else begin
          state_d   = DATA;
          cnt_load  = 1'b1;
          bit_idx_d = '0;
          perr_d    = 1'b0;
        end
      end
      DATA: if (tick) begin
        shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
        cnt_load  = 1'b1;
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'(DATA_BITS-1)) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (tick) begin
        perr_d   = rx_s != ((^shift_q) ^ PAR_ODD_BIT);
        cnt_load = 1'b1;
        state_d  = STOP;
      end
      STOP: if (tick) begin
        state_d = IDLE;
        if (!rx_ready_q || rx_clr) begin
          rx_data_d    = shift_q;
          rx_ready_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err_d = perr_q;
`else
          parity_err_d = 1'b0;
`endif
          frame_err_d  = ~rx_s;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync_q       <= 2'b11;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_ready_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_ready_q   <= rx_ready_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_ready   = rx_ready_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);
endmodule
